// File: rtl/ram_fifo_pkg.sv
// Shared constants and access-state encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, WR, RD} acc_state_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake, status and external RAM bus of the FIFO controller.
interface ram_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int AW = ram_fifo_pkg::AW,
    parameter int DW = ram_fifo_pkg::DW
);
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop_req;
    logic          pop_ack;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ram_wr;
    logic          ram_rd;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  push_valid, push_data, pop_req, ram_dout,
        output push_ready, pop_ack, pop_valid, pop_data, count, full, empty,
               ram_wr, ram_rd, ram_add, ram_din
    );

    modport master (
        output push_valid, push_data, pop_req, ram_dout,
        input  push_ready, pop_ack, pop_valid, pop_data, count, full, empty,
               ram_wr, ram_rd, ram_add, ram_din
    );
endinterface

// File: rtl/ram_fifo_ctrl_arb_rr2.sv
// Two-requester round-robin arbiter; contested grants alternate, uncontested grants pass straight through.
module arb_rr2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_push,
    input  logic req_pop,
    output logic gnt_push,
    output logic gnt_pop
);
    logic last_pop;

    // Out of reset last_pop=1, so the first contest goes to push.
    assign gnt_push = req_push && (!req_pop || last_pop);
    assign gnt_pop  = req_pop && !gnt_push;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_pop <= 1'b1;
        else if (req_push && req_pop)
            last_pop <= gnt_pop;
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external single-port RAM: one RAM access per cycle, 2-cycle pop latency.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int AW = ram_fifo_pkg::AW,
    parameter int DW = ram_fifo_pkg::DW
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_fifo_ctrl_if.slave   bus
);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          push_elig, pop_elig, push_gnt, pop_gnt;
    acc_state_t    state, state_nxt;

    assign bus.count = cnt;
    assign bus.full  = (cnt == FULL_CNT);
    assign bus.empty = (cnt == '0);

    // Grants are forced low while reset is asserted.
    assign push_elig = rst_n && bus.push_valid && !bus.full;
    assign pop_elig  = rst_n && bus.pop_req && !bus.empty;

    arb_rr2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_push (push_elig),
        .req_pop  (pop_elig),
        .gnt_push (push_gnt),
        .gnt_pop  (pop_gnt)
    );

    assign bus.push_ready = push_gnt;
    assign bus.pop_ack    = pop_gnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push_gnt)     state_nxt = WR;
                else if (pop_gnt) state_nxt = RD;
            end
            WR, RD: begin
                if (push_gnt)     state_nxt = WR;
                else if (pop_gnt) state_nxt = RD;
                else              state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            cnt           <= '0;
            bus.ram_wr    <= 1'b0;
            bus.ram_rd    <= 1'b0;
            bus.ram_add   <= '0;
            bus.ram_din   <= '0;
            bus.pop_valid <= 1'b0;
            bus.pop_data  <= '0;
        end else begin
            state      <= state_nxt;
            bus.ram_wr <= (state_nxt == WR);
            bus.ram_rd <= (state_nxt == RD);
            // Address and write data hold their last value on idle cycles.
            if (push_gnt) begin
                bus.ram_add <= wptr;
                bus.ram_din <= bus.push_data;
                wptr        <= wptr + 1'b1;
                cnt         <= cnt + 1'b1;
            end else if (pop_gnt) begin
                bus.ram_add <= rptr;
                rptr        <= rptr + 1'b1;
                cnt         <= cnt - 1'b1;
            end
            bus.pop_valid <= bus.ram_rd;
            if (bus.ram_rd)
                bus.pop_data <= bus.ram_dout;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl against a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus();
    ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.ram_wr) mem[bus.ram_add] <= bus.ram_din;
    assign bus.ram_dout = mem[bus.ram_add];

    int checks = 0;
    int failures = 0;

    // Reference model: contents as a queue, pointers as plain modular counters.
    logic [7:0] q[$];
    int         wp = 0, rp = 0;
    bit         last_pop = 1'b1;
    bit         e_wr = 0, e_rd = 0, e_pv = 0, rd_pend = 0;
    int         e_add = 0;
    logic [7:0] e_din = '0, e_pd = '0, rd_data = '0;
    int         wr_log[$], rd_log[$];
    bit         gnt_log[$];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(bit pv, logic [7:0] pd, bit pr, bit rst = 1'b1);
        bit pe, oe, gp, go;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_req    = pr;
        rst_n          = rst;
        #4;
        pe = rst && pv && (q.size() < DEPTH);
        oe = rst && pr && (q.size() > 0);
        gp = pe && (!oe || last_pop);
        go = oe && !gp;
        chk("push_ready", bus.push_ready, gp);
        chk("pop_ack", bus.pop_ack, go);
        chk("count", bus.count, q.size());
        chk("full", bus.full, q.size() == DEPTH);
        chk("empty", bus.empty, q.size() == 0);
        chk("ram_wr", bus.ram_wr, e_wr);
        chk("ram_rd", bus.ram_rd, e_rd);
        chk("ram_add", bus.ram_add, e_add);
        chk("ram_din", bus.ram_din, e_din);
        chk("wr_rd_excl", bus.ram_wr & bus.ram_rd, 0);
        chk("pop_valid", bus.pop_valid, e_pv);
        chk("pop_data", bus.pop_data, e_pd);
        if (bus.ram_wr) wr_log.push_back(int'(bus.ram_add));
        if (bus.ram_rd) rd_log.push_back(int'(bus.ram_add));
        if (gp || go) gnt_log.push_back(gp);
        @(posedge clk);
        if (!rst) begin
            q.delete();
            wp = 0; rp = 0; last_pop = 1'b1;
            e_wr = 0; e_rd = 0; e_add = 0; e_din = '0;
            e_pv = 0; e_pd = '0; rd_pend = 0;
        end else begin
            e_pv = rd_pend;
            if (rd_pend) e_pd = rd_data;
            rd_pend = go;
            if (go) rd_data = q.pop_front();
            if (pe && oe) last_pop = go;
            e_wr = gp;
            e_rd = go;
            if (gp) begin
                e_add = wp; e_din = pd; q.push_back(pd);
                wp = (wp + 1) % DEPTH;
            end
            if (go) begin
                e_add = rp;
                rp = (rp + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state; requests during reset must not be granted.
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        idle(1);

        // Single byte round trip.
        cycle(1'b1, 8'hA5, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 1'b1);
        idle(3);
        chk("a5_data", bus.pop_data, 8'hA5);
        chk("a5_empty", bus.empty, 1);

        // Fill to full, attempt one more, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        bus.push_valid = 1'b1;
        #1;
        chk("full_flag", bus.full, 1);
        chk("full_push_ready", bus.push_ready, 0);
        cycle(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        idle(3);
        chk("drain_empty", bus.empty, 1);

        // Contested traffic around count=5.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
        idle(1);
        gnt_log.delete();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'($urandom), 1'b1);
            chk("cnt_range", (bus.count >= 5) && (bus.count <= 6), 1);
        end
        chk("alt_len", gnt_log.size(), 20);
        for (int i = 0; i < gnt_log.size(); i++) chk("alt_grant", gnt_log[i], (i % 2) == 0);
        idle(3);

        // Pointer wrap 1022 -> 1.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 2; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
        end
        idle(3);
        wr_log.delete();
        rd_log.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        idle(3);
        chk("wrap_wr_n", wr_log.size(), 4);
        chk("wrap_rd_n", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("wrap_wadd", wr_log[i], (DEPTH - 2 + i) % DEPTH);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_radd", rd_log[i], (DEPTH - 2 + i) % DEPTH);

        // Pop on empty is ignored; reset right after a pop_ack aborts it.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rd_log.delete();
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        chk("empty_no_rd", rd_log.size(), 0);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);
        chk("abort_count", bus.count, 0);
        chk("abort_data", bus.pop_data, 0);

        // Random traffic with phase-biased fill level and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 300) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(0, 99) < bias, 8'($urandom),
                  $urandom_range(0, 99) < (100 - bias), $urandom_range(0, 399) != 0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 10, RAM address width; depth = 2^AW = 1024.
- DW, 8, data width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset; synchronous, active-low.
- push_valid, in, 1, producer has a byte.
- push_data, in, DW, producer byte.
- push_ready, out, 1, push accepted this edge when push_valid=1.
- pop_req, in, 1, consumer requests one byte.
- pop_ack, out, 1, pop_req accepted this edge.
- pop_valid, out, 1, pop_data valid; one-cycle pulse.
- pop_data, out, DW, popped byte.
- count, out, AW+1, entries held (0..1024).
- full, out, 1, count==1024.
- empty, out, 1, count==0.
- ram_wr, out, 1, RAM write strobe.
- ram_rd, out, 1, RAM read strobe.
- ram_add, out, AW, RAM address.
- ram_din, out, DW, RAM write data.
- ram_dout, in, DW, RAM read data; treated as valid while ram_rd=1.

Function
REQ-003 The block SHALL implement a 1024x8 FIFO using the external single-address RAM as storage, issuing at most one RAM access per cycle.
REQ-004 All ram_* outputs SHALL be registered and held constant for one full cycle per access; ram_wr and ram_rd SHALL never both be 1.
REQ-005 Grant logic SHALL be combinational:
- push_ready = push_valid && !full && (push wins).
- pop_ack = pop_req && !empty && (pop wins).
REQ-006 When push and pop are both eligible in the same cycle, grant SHALL alternate using a 1-bit last_grant register:
- Grant the side not granted last time.
- last_grant updates only on a contested grant.
- last_grant resets to "pop", so the first contest goes to push.
REQ-007 When only one side is eligible, that side SHALL be granted regardless of last_grant.
REQ-008 A push accepted at edge N SHALL cause, in cycle N+1: ram_wr=1, ram_add=wptr, ram_din=push_data. wptr SHALL increment modulo 1024 at edge N.
REQ-009 A pop accepted at edge N SHALL cause, in cycle N+1: ram_rd=1, ram_add=rptr. rptr SHALL increment modulo 1024 at edge N.
REQ-010 At edge N+1 the block SHALL capture ram_dout into pop_data and pulse pop_valid=1 during cycle N+2 (pop latency 2 cycles). pop_data SHALL hold its value until the next pop.
REQ-011 count SHALL update at the accepting edge: +1 on push, -1 on pop. Since only one grant occurs per cycle, count never changes by more than 1.
REQ-012 full and empty SHALL be decoded from count.
REQ-013 Boundary behaviour:
- When full, push_ready=0.
- When empty, pop_ack=0 and pop_req is ignored, not queued.
- A push followed by a pop on the next cycle SHALL return the pushed byte (write cycle precedes read cycle).
REQ-014 Pointer wrap from 1023 to 0 SHALL be seamless. Data order SHALL be strictly FIFO.
REQ-015 The access type of the current cycle SHALL be tracked by a 3-state machine:
- IDLE -> WR on push grant, -> RD on pop grant.
- WR/RD -> WR, RD or IDLE per the grant at that edge.
- No other transitions.

Reset
REQ-016 When rst_n=0 at a rising edge, the following SHALL be cleared: wptr, rptr, count, last_grant(=pop), state=IDLE, ram_wr=0, ram_rd=0, ram_add=0, ram_din=0, pop_valid=0, pop_data=0.
REQ-017 Reset SHALL abort any in-flight pop: no pop_valid after reset release for a pop accepted before reset. RAM contents are not cleared.
REQ-018 During reset, push_ready and pop_ack SHALL be 0. After reset: empty=1, full=0, count=0.

Structure
REQ-019 A shared package ram_fifo_pkg SHALL hold AW, DW, DEPTH=1024, and the state enum {IDLE, WR, RD}.
REQ-020 Sub-module: a 2-requester round-robin arbiter, arb_rr2, SHALL implement REQ-005 to REQ-007. The RAM itself is external, not instantiated.

Verification
REQ-021 Reset then push 0xA5 -> cycle+1: ram_wr=1, ram_add=0, ram_din=0xA5; count=1. Then pop -> pop_valid with pop_data=0xA5, 2 cycles after pop_ack; empty=1.
REQ-022 Push 1024 bytes (value = index mod 256) -> full=1, push_ready=0 on the 1025th attempt. Pop all -> identical sequence, then empty=1.
REQ-023 Continuous push_valid and pop_req with count=5 -> grants alternate, starting with push on the first contest; count stays in 5..6; no cycle with ram_wr=ram_rd=1.
REQ-024 Pre-advance pointers to 1022, then push 4 and pop 4 -> ram_add sequence 1022, 1023, 0, 1; data order preserved.
REQ-025 pop_req on empty -> pop_ack=0, no ram_rd, no pop_valid. Assert rst_n=0 in the cycle after a pop_ack -> no pop_valid, count=0.
